// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx
// Serial-in, parallel-out frame receiver. Samples `si` on clock edges where
// si_en=1, detects a start bit (1), shifts in WIDTH data bits MSB first and
// checks the stop bit (0). Good words land in a one-entry valid/ready
// holding register.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   si_en      sample enable for si
//   si         serial line, idle 0
//   po         holding register (received word)
//   po_valid   po holds an unconsumed word
//   po_ready   consumer accepts po when po_valid=1
//   frame_err  one-cycle pulse: stop bit sampled as 1, word dropped
//   overrun    one-cycle pulse: word completed while holding reg full and
//              not draining, word dropped
//   busy       receiver is inside a frame
//   counter    data bits received in the current/last frame
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a sampled start bit
// DATA  | shifting in data bits, counter counts them
// STOP  | next sample is the stop bit; completes or flags the frame
module sipo_frame_rx #(
   parameter int WIDTH = 4,
   localparam int CW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             si_en,
   input  logic             si,
   output logic [WIDTH-1:0] po,
   output logic             po_valid,
   input  logic             po_ready,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy,
   output logic [CW-1:0]    counter
);

   typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shift_reg, shift_nxt;
   logic [CW-1:0]    cnt_nxt;
   logic [WIDTH-1:0] po_nxt;
   logic             vld_nxt;
   logic             ferr_nxt;
   logic             ovr_nxt;
   logic             done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shift_reg <= '0;
         counter   <= '0;
         po        <= '0;
         po_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         shift_reg <= shift_nxt;
         counter   <= cnt_nxt;
         po        <= po_nxt;
         po_valid  <= vld_nxt;
         frame_err <= ferr_nxt;
         overrun   <= ovr_nxt;
         busy      <= (state_nxt != IDLE);
      end
   end

   always_comb begin
      state_nxt = state;
      shift_nxt = shift_reg;
      cnt_nxt   = counter;
      po_nxt    = po;
      vld_nxt   = po_valid;
      ferr_nxt  = 1'b0;
      ovr_nxt   = 1'b0;
      done      = 1'b0;

      // Consumer handshake runs every edge, independent of si_en.
      if (po_valid && po_ready)
         vld_nxt = 1'b0;

      if (si_en) begin
         case (state)
            IDLE: begin
               if (si) begin
                  state_nxt = DATA;
                  cnt_nxt   = '0;
               end
            end
            DATA: begin
               shift_nxt = {shift_reg[WIDTH-2:0], si};
               cnt_nxt   = counter + CW'(1);
               if (counter == CW'(WIDTH - 1))
                  state_nxt = STOP;
            end
            STOP: begin
               // Always back to IDLE; a 1 here is a framing error, never a start.
               state_nxt = IDLE;
               if (si)
                  ferr_nxt = 1'b1;
               else
                  done = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end

      // An accept on the completion edge frees the slot for the new word.
      if (done) begin
         if (!po_valid || po_ready) begin
            po_nxt  = shift_reg;
            vld_nxt = 1'b1;
         end else begin
            ovr_nxt = 1'b1;
         end
      end
   end

endmodule
